// File: rtl/wave_capture_buffer.sv
// Double-buffered waveform capture: grabs one frame of samples from a
// rising zero crossing and flips halves only while the display is idle.
module wave_capture_buffer #(
  parameter int NUM_SAMPLES = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample_ready,
  input  logic [15:0]       new_sample_in,
  input  logic              wave_display_idle,
  output logic [ADDR_W:0]   write_address,
  output logic              write_enable,
  output logic [7:0]        write_sample,
  output logic              read_index,
  output logic [1:0]        capture_state
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              prev_neg_q, prev_neg_d;
  logic              read_index_q, read_index_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [7:0]        sample_q, sample_d;

  logic              crossing;
  logic              store;
  logic [ADDR_W-1:0] store_idx;

  // prev_neg is the sign of the previous strobed sample, in any state
  assign crossing = new_sample_ready & prev_neg_q & ~new_sample_in[15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:  if (crossing) state_d = ACTIVE;
      ACTIVE: if (new_sample_ready && count_q == LAST) state_d = WAIT;
      WAIT:   if (wave_display_idle) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    store        = 1'b0;
    store_idx    = '0;
    count_d      = count_q;
    read_index_d = read_index_q;
    unique case (state_q)
      ARMED: begin
        store     = crossing;
        store_idx = '0;
        if (crossing) count_d = ADDR_W'(1);
      end
      ACTIVE: begin
        store     = new_sample_ready;
        store_idx = count_q;
        if (new_sample_ready) count_d = count_q + 1'b1;
      end
      WAIT: begin
        if (wave_display_idle) read_index_d = ~read_index_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    prev_neg_d = new_sample_ready ? new_sample_in[15] : prev_neg_q;
    we_d       = store;
    addr_d     = addr_q;
    sample_d   = sample_q;
    if (store) begin
      addr_d   = {~read_index_q, store_idx};
      sample_d = {~new_sample_in[15], new_sample_in[14:8]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      prev_neg_q   <= 1'b0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sample_q     <= '0;
    end else begin
      count_q      <= count_d;
      prev_neg_q   <= prev_neg_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sample_q     <= sample_d;
    end
  end

  assign write_address = addr_q;
  assign write_enable  = we_q;
  assign write_sample  = sample_q;
  assign read_index    = read_index_q;
  assign capture_state = state_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer: framing, half flip, conversion,
// async reset and back-to-back strobes.
module tb_wave_capture_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] din = '0;
  logic        idle = 1'b0;
  logic [8:0]  waddr;
  logic        we;
  logic [7:0]  wsamp;
  logic        ridx;
  logic [1:0]  cst;

  int checks = 0;
  int failures = 0;

  wave_capture_buffer #(.NUM_SAMPLES(256), .ADDR_W(8)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .new_sample_ready  (ready),
    .new_sample_in     (din),
    .wave_display_idle (idle),
    .write_address     (waddr),
    .write_enable      (we),
    .write_sample      (wsamp),
    .read_index        (ridx),
    .capture_state     (cst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then land 1ns after the edge
  task automatic cyc(input logic r, input logic [15:0] d,
                     input logic i);
    ready = r;
    din   = d;
    idle  = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    #12;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(waddr), 32'h000);
    chk("rst_samp", 32'(wsamp), 32'h00);
    chk("rst_ridx", 32'(ridx), 32'd0);
    chk("rst_state", 32'(cst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: first crossing
    cyc(1'b1, 16'h0100, 1'b0);
    chk("t1_nowr0", 32'(we), 32'd0);
    cyc(1'b1, 16'hFF00, 1'b0);
    chk("t1_nowr1", 32'(we), 32'd0);
    cyc(1'b1, 16'h0200, 1'b0);
    chk("t1_wr", 32'({we, waddr, wsamp}), 32'({1'b1, 9'h100, 8'h82}));
    chk("t1_state", 32'(cst), 32'd1);

    // 2: fill the rest of the frame
    for (int i = 1; i < 256; i++) begin
      cyc(1'b1, 16'h7FFF, 1'b0);
      chk("t2_wr", 32'({we, waddr, wsamp}),
          32'({1'b1, 9'(32'h100 + i), 8'hFF}));
    end
    chk("t2_state", 32'(cst), 32'd2);
    chk("t2_ridx", 32'(ridx), 32'd0);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("t2_idle_we", 32'(we), 32'd0);

    // 3: WAIT ignores samples, then flips on idle
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 16'h8000 : 16'h1000, 1'b0);
      chk("t3_nowr", 32'({we, cst}), 32'({1'b0, 2'd2}));
    end
    cyc(1'b0, 16'h0000, 1'b1);
    chk("t3_ridx", 32'(ridx), 32'd1);
    chk("t3_state", 32'(cst), 32'd0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("t3_armed_idle", 32'({ridx, cst}), 32'({1'b1, 2'd0}));

    // 4: exact zero after negative triggers; conversion extremes
    cyc(1'b1, 16'h8000, 1'b0);
    chk("t4_neg_nowr", 32'(we), 32'd0);
    cyc(1'b1, 16'h0000, 1'b0);
    chk("t4_zero", 32'({we, waddr, wsamp}), 32'({1'b1, 9'h000, 8'h80}));
    cyc(1'b1, 16'h8000, 1'b0);
    chk("t4_min", 32'({we, waddr, wsamp}), 32'({1'b1, 9'h001, 8'h00}));

    // 5: async reset mid-frame with a write showing
    for (int i = 2; i < 37; i++) begin
      cyc(1'b1, 16'h0100, 1'b0);
      chk("t5_wr", 32'({we, waddr}), 32'({1'b1, 9'(i)}));
    end
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 32'(we), 32'd0);
    chk("t5_rst_ridx", 32'(ridx), 32'd0);
    chk("t5_rst_state", 32'(cst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 16'h0000, 1'b0);
    chk("t5_first_nowr", 32'({we, cst}), 32'({1'b0, 2'd0}));

    // 6: back-to-back strobes through a full frame
    cyc(1'b1, 16'h8000, 1'b0);
    chk("t6_pre", 32'(we), 32'd0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      cyc(1'b1, {b, 8'h00}, 1'b0);
      chk("t6_wr", 32'({we, waddr, wsamp}),
          32'({1'b1, 9'(32'h100 + i), b ^ 8'h80}));
    end
    chk("t6_state", 32'(cst), 32'd2);

    // crossing coincident with WAIT->ARMED is not captured
    cyc(1'b1, 16'hFF00, 1'b0);
    chk("t7_neg", 32'(we), 32'd0);
    cyc(1'b1, 16'h0100, 1'b1);
    chk("t7_flip", 32'({we, ridx, cst}), 32'({1'b0, 1'b1, 2'd0}));
    cyc(1'b1, 16'h0200, 1'b0);
    chk("t7_nowr", 32'({we, cst}), 32'({1'b0, 2'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Sits downstream of the music player and taps its final 16-bit codec sample stream plus the one-cycle new-sample strobe.
- Captures one screen's worth of samples, starting at a positive-going zero crossing, into one half of a double-buffered display RAM.
- Flips halves only when the waveform display reports it is idle between frames, so the display never reads a half that is still being written.
- Emits RAM write strobes, an address and a byte-wide offset-binary sample each cycle a sample is stored.

Parameters:
- NUM_SAMPLES, 256, samples captured per frame; must be a power of two.
- ADDR_W, 8, log2(NUM_SAMPLES); width of the in-half sample index.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset; 0 clears all state
- new_sample_ready  input  1  one-cycle strobe, high when new_sample_in is valid
- new_sample_in  input  16  signed two's-complement audio sample
- wave_display_idle  input  1  high while the display is outside the active drawing region
- write_address  output  ADDR_W+1  RAM address; MSB selects the half, low bits are the sample index
- write_enable  output  1  one-cycle RAM write strobe
- write_sample  output  8  offset-binary sample byte
- read_index  output  1  half the display must read from; the capture side writes the other half
- capture_state  output  2  current FSM state, for debug (ARMED=0, ACTIVE=1, WAIT=2)

Behaviour:
- Reset (reset=0, asynchronous) sets: state=ARMED, count=0, prev_neg=0, read_index=0, write_enable=0, write_address=0, write_sample=0. Outputs hold these values until the first qualifying event.
- prev_neg register: on every new_sample_ready in every state, loads new_sample_in[15]; otherwise holds. Crossing = new_sample_ready & prev_neg & ~new_sample_in[15], using the old prev_neg.
- Sample conversion: write_sample = {~new_sample_in[15], new_sample_in[14:8]}, so 0x8000→0x00, 0x0000→0x80, 0x7FFF→0xFF.
- Write outputs are registered; latency is 1 cycle.
  - A store accepted in cycle N gives write_enable=1 in N+1, with write_address={~read_index, index} and write_sample set in the same cycle.
  - write_enable=0 in every other cycle.
  - write_address and write_sample hold their last values when write_enable=0.
- FSM:
  - ARMED: when a crossing occurs, store the crossing sample at index 0, set count=1, go to ACTIVE. A new_sample_ready with no crossing stores nothing. wave_display_idle is ignored.
  - ACTIVE: on each new_sample_ready, store at index=count and increment count.
    - When the sample at index NUM_SAMPLES-1 is stored, count wraps to 0 and the state goes to WAIT in the same cycle.
    - No crossing check is made in ACTIVE. wave_display_idle is ignored.
  - WAIT: new_sample_ready stores nothing, but prev_neg still tracks. When wave_display_idle=1, toggle read_index and go to ARMED.
- Boundaries:
  - A crossing sample arriving in the same cycle as the WAIT→ARMED transition is not captured; arming takes effect the following cycle.
  - A sample exactly 0x0000 after a negative sample counts as a crossing.
  - The first sample after reset never triggers, because prev_neg=0.
  - A write pending in the output register when reset asserts is discarded, and write_enable drops immediately.
  - Back-to-back new_sample_ready strobes on consecutive cycles must each be stored; no minimum spacing is assumed.
- read_index changes only on the WAIT→ARMED transition.
- The write half is always the complement of read_index at the time of the store.

Test Plan:
1. Reset, then drive samples 0x0100, 0xFF00, 0x0200 → no writes for the first two; the third gives write_enable=1 the next cycle with write_address=0x100 and write_sample=0x82. capture_state=ACTIVE.
2. Continue with 255 more samples of 0x7FFF → 255 writes at addresses 0x101..0x1FF, each with write_sample=0xFF. After the last write, capture_state=WAIT and read_index stays 0.
3. In WAIT, inject 10 samples alternating between negative and positive → no writes. Then pulse wave_display_idle → read_index=1 and capture_state=ARMED next cycle. The next crossing writes at address 0x000.
4. Drive 0x8000 then 0x0000 → crossing detected; write_sample=0x80 at index 0. Then drive 0x8000 → write_sample=0x00 at index 1.
5. Mid-ACTIVE at count=37, assert reset=0 for one cycle → write_enable=0 immediately; read_index=0, capture_state=ARMED. A non-crossing sample afterwards produces no write.
6. Drive new_sample_ready on consecutive cycles through a crossing with 256 samples → exactly 256 writes with contiguous addresses and no skips.
